// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and data access (D).
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on ties; default is fixed D priority.
module mem_port_arbiter #(
  parameter int unsigned N   = 31,
  parameter int unsigned LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [N:0] d_wdata,
  input  logic [N:0] mem_rdata,
  output logic       sel,
  output logic       mem_en,
  output logic       mem_we,
  output logic [N:0] mem_wdata,
  output logic [N:0] rdata,
  output logic       i_done,
  output logic       d_done
);

  localparam int unsigned   CW      = $clog2(LAT) + 1;
  localparam logic [CW-1:0] LastCnt = CW'(LAT - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_grant_q, last_grant_d;
  logic          sel_q, sel_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [N:0]    mem_wdata_q, mem_wdata_d;
  logic [N:0]    rdata_q, rdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;

  logic          i_req_m, d_req_m, tie_to_d, grant;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;

    // A requester just completed gets one cycle to drop its request.
    i_req_m = i_req & ~i_done_q;
    d_req_m = d_req & ~d_done_q;
`ifdef ARB_ROUND_ROBIN_EN
    tie_to_d = ~last_grant_q;
`else
    tie_to_d = 1'b1;
`endif
    grant = d_req_m & (~i_req_m | tie_to_d);

    unique case (state_q)
      StIdle: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (i_req_m | d_req_m) begin
          state_d      = StBusy;
          count_d      = '0;
          last_grant_d = grant;
          sel_d        = grant;
          mem_en_d     = 1'b1;
          mem_we_d     = d_we & grant;
          if (grant) mem_wdata_d = d_wdata;
        end
      end
      StBusy: begin
        count_d = count_q + CW'(1);
        if (count_q == LastCnt) begin
          state_d  = StIdle;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          rdata_d  = mem_rdata;
          i_done_d = ~last_grant_q;
          d_done_d = last_grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      last_grant_q <= 1'b0;
      sel_q        <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  assign sel       = sel_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts each access
// (who, done cycle, read data); a separate monitor checks DUT outputs every cycle.
module tb_mem_port_arbiter;

  localparam int unsigned N   = 31;
  localparam int unsigned LAT = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req, d_req, d_we;
  logic [N:0] d_wdata, mem_rdata;
  logic       sel, mem_en, mem_we, i_done, d_done;
  logic [N:0] mem_wdata, rdata;

  mem_port_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_wdata   (d_wdata),
    .mem_rdata (mem_rdata),
    .sel       (sel),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .rdata     (rdata),
    .i_done    (i_done),
    .d_done    (d_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         who;   // 1 = D
    int         cyc;   // cycle in which done must be high
    logic [N:0] rdata;
    bit         we;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         mon_en  = 1'b0;

  // Model state: one access at a time, tracked as cycle numbers.
  int         idle_from = 0;
  int         done_at_i = -1;
  int         done_at_d = -1;
  bit         last_g    = 1'b0;
  bit         sel_exp   = 1'b0;
  logic [N:0] wdata_exp = '0;

  function automatic logic [N:0] rd_fn(input int j);
    return (N+1)'(j) * 32'h9E37_79B1 + 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  // Evaluate the arbitration rules for the inputs presented in the current cycle.
  task automatic model_cycle();
    int  c;
    bit  im, dm, g;
    exp_t e;
    c = cyc;
    if (rst) begin
      exp_q.delete();
      idle_from = c + 1;
      done_at_i = -1;
      done_at_d = -1;
      last_g    = 1'b0;
      sel_exp   = 1'b0;
      wdata_exp = '0;
    end else if (c >= idle_from) begin
      im = i_req && (done_at_i != c);
      dm = d_req && (done_at_d != c);
      if (im || dm) begin
        if (im && dm) g = RR ? !last_g : 1'b1;
        else          g = dm;
        last_g    = g;
        sel_exp   = g;
        if (g) wdata_exp = d_wdata;
        e.who     = g;
        e.cyc     = c + LAT + 1;
        e.rdata   = rd_fn(c + LAT);
        e.we      = g && d_we;
        exp_q.push_back(e);
        idle_from = c + LAT + 1;
        if (g) done_at_d = c + LAT + 1;
        else   done_at_i = c + LAT + 1;
      end
    end
  endtask

  task automatic step();
    model_cycle();
    @(negedge clk);
    mem_rdata = rd_fn(cyc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sel"}, N'(sel), '0);
    chk({tag, "_mem_en"}, N'(mem_en), '0);
    chk({tag, "_mem_we"}, N'(mem_we), '0);
    chk({tag, "_mem_wdata"}, mem_wdata, '0);
    chk({tag, "_rdata"}, rdata, '0);
    chk({tag, "_i_done"}, N'(i_done), '0);
    chk({tag, "_d_done"}, N'(d_done), '0);
  endtask

  // Monitor: compares every cycle against the scoreboard head.
  initial begin
    exp_t e;
    bit   busy;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        busy = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc - LAT) && (cyc < exp_q[0].cyc);
        chk("mem_en", N'(mem_en), N'(busy));
        chk("mem_we", N'(mem_we), N'(busy && exp_q[0].we));
        chk("sel", N'(sel), N'(sel_exp));
        chk("mem_wdata", mem_wdata, wdata_exp);
        chk("done_exclusive", N'(i_done & d_done), '0);
        if (i_done || d_done) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_done cyc=%0d got i=%0b d=%0b want none", cyc, i_done, d_done);
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", N'(cyc), N'(e.cyc));
            chk("done_who", N'(d_done), N'(e.who));
            chk("rdata", rdata, e.rdata);
          end
        end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
          e = exp_q.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_done cyc=%0d got none want who=%0b", cyc, e.who);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    mem_rdata = rd_fn(0);
    @(negedge clk);
    mem_rdata = rd_fn(cyc);
    step();
    step();
    rst = 1'b0;
    check_zero("reset");
    mon_en = 1'b1;

    // D write aborted by a two-cycle reset in its first BUSY cycle.
    d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h1234_5678;
    step();
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'hFFFF_0000;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_zero("abort");

    // Single fetch, held until done.
    i_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (cyc == done_at_i) i_req = 1'b0;
      step();
    end

    // Simultaneous requests, both held until their own done.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wdata = 32'hCAFE_F00D;
    for (int k = 0; k < 16; k++) begin
      if (cyc == done_at_i) i_req = 1'b0;
      if (cyc == done_at_d) d_req = 1'b0;
      step();
    end

    // Randomized traffic, including drops during service and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(199) == 0);
      d_we    = $urandom_range(1) == 1;
      d_wdata = $urandom;
      if (cyc < done_at_i) begin
        if ($urandom_range(7) == 0) i_req = 1'b0;
      end else if (cyc == done_at_i) begin
        if ($urandom_range(1) == 0) i_req = 1'b0;
      end else if (!i_req) begin
        i_req = ($urandom_range(2) == 0);
      end
      if (cyc < done_at_d) begin
        if ($urandom_range(7) == 0) d_req = 1'b0;
      end else if (cyc == done_at_d) begin
        if ($urandom_range(1) == 0) d_req = 1'b0;
      end else if (!d_req) begin
        d_req = ($urandom_range(2) == 0);
      end
      step();
    end

    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < LAT + 4; k++) step();
    chk("drained", N'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
